ring_router_input_unit: RTL and testbench
=========================================

Name: ring_router_input_unit

Overview:
Input stage of a ring-network router port. It accepts messages from the upstream channel into a small FIFO and computes the greedy route (prev/next/term) for each message as it is enqueued. The route is stored beside the message. The head message is presented to exactly one of three downstream output arbiters and is dequeued when that arbiter grants it.

Parameters:
p_router_id, 0, this router's index on the ring
p_num_routers, 8, routers on the ring; power of two, at least 2
p_msg_nbits, 44, total message width; destination field is bits [p_msg_nbits-1 -: c_dest_nbits]
p_num_entries, 2, FIFO depth; power of two, at least 2
c_dest_nbits, $clog2(p_num_routers), derived; not set externally

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
domain  in  1  security domain of this port; static
in_val  in  1  upstream message valid
in_rdy  out  1  unit can accept a message
in_msg  in  p_msg_nbits  upstream message
out_msg  out  p_msg_nbits  head message, shared by all three outputs
out_val  out  3  one-hot request; bit0 = prev, bit1 = next, bit2 = term
out_rdy  in  3  per-output grant/ready from the output arbiters
route  out  2  head route code: 00 prev, 01 next, 10 term

Behaviour:
- Reset: while reset=0, asynchronously clear head pointer, tail pointer and count. Outputs during and after reset:
  - in_rdy=1
  - out_val=000
  - route=00
  - out_msg=0
- The storage array is not reset. out_msg is forced to 0 whenever the FIFO is empty.
- Route computation, combinational on in_msg, c_dest_nbits modulo arithmetic:
  - fwd = dest - p_router_id; bwd = p_router_id - dest.
  - dest == p_router_id → term (10).
  - else fwd < bwd (unsigned) → next (01).
  - else → prev (00). Ties go to prev.
- The computed route code is written into the FIFO entry together with in_msg.
- Enqueue: fires when in_val && in_rdy. in_rdy = (count != p_num_entries); it does not depend on out_rdy (no full-bypass).
- Output presentation:
  - When count > 0, out_val has exactly one bit set, selected by the head's stored route; route = that code; out_msg = head message.
  - When count == 0, out_val = 000 and route = 00.
- Dequeue: fires when the head's selected out_val bit is 1 and the matching out_rdy bit is 1. out_rdy bits for unselected outputs are ignored.
- Latency: a message enqueued at edge k is visible on out_val after edge k. Minimum 1 cycle; no combinational in→out path.
- Simultaneous enqueue and dequeue: allowed whenever in_rdy=1. count is unchanged; both pointers advance.
- Pointers are log2(p_num_entries) bits and wrap naturally.
- Ordering: strict FIFO. A blocked head blocks all later messages, even those with a different route (head-of-line blocking is intended).
- Full (count == p_num_entries): in_rdy=0. in_val is ignored and no state changes from the input side.
- Empty: out_val=000 regardless of out_rdy.
- Reset mid-operation: all queued messages are discarded immediately. The next valid input after reset deasserts is treated as the first message.
- domain: carried for labelling only and does not alter function. All datapath signals are in the security level of domain.
- Invariants:
  - out_val is never non-one-hot.
  - count never exceeds p_num_entries.
  - No dequeue occurs while empty.

Test Plan:
- Route decode (p_router_id=2, p_num_routers=8): enqueue dest=2,3,5,6,7 with out_rdy=111 → route 10,01,01,00,00 and out_val 100,010,010,001,001, in order, one per cycle after a 1-cycle initial latency.
- Fill/backpressure (p_num_entries=2): out_rdy=000, in_val=1 for 4 cycles with msgs A,B,C,D → only A,B accepted; in_rdy=0 from cycle 2. Raise out_rdy=111 → A, then B drain; in_rdy returns to 1 the cycle after A dequeues.
- Wrong-port grant: head route=next (out_val=010), drive out_rdy=101 for 3 cycles → no dequeue and out_msg stable. Drive out_rdy=010 → dequeue in that cycle.
- Simultaneous enqueue/dequeue at count=1: in_val=1 and head granted in the same cycle → count stays 1 and the new message becomes head next cycle. Stream 8 messages back-to-back at full throughput to exercise pointer wrap.
- Async reset: with 2 messages queued, pulse reset low mid-cycle → out_val=000 and in_rdy=1 immediately, without waiting for clk. After release, enqueue dest=0 (router 2) → route 00, prev.
- Tie case (p_router_id=0, p_num_routers=4): dest=2 gives fwd=bwd=2 → route 00 (prev); dest=1 → next; dest=3 → prev.

Source files
------------

// File: rtl/ring_router_input_unit.sv
// Ring router input unit: small FIFO that stores each upstream message together
// with its greedy ring route (prev/next/term), computed when the message is
// enqueued. The head is offered to exactly one of three output arbiters and
// leaves the FIFO when that arbiter grants it. Strict FIFO order is kept, so a
// blocked head holds back every later message.
module ring_router_input_unit #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   domain,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic [2:0]             out_val,
  input  logic [2:0]             out_rdy,
  output logic [1:0]             route
);

  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam int c_ptr_nbits  = $clog2(p_num_entries);
  localparam int c_cnt_nbits  = c_ptr_nbits + 1;

  localparam logic [c_dest_nbits-1:0] c_id   = c_dest_nbits'(p_router_id);
  localparam logic [c_cnt_nbits-1:0]  c_full = c_cnt_nbits'(p_num_entries);

  localparam logic [1:0] ROUTE_PREV = 2'b00;
  localparam logic [1:0] ROUTE_NEXT = 2'b01;
  localparam logic [1:0] ROUTE_TERM = 2'b10;

  // domain only labels the security level of this whole datapath; it never
  // steers any logic.
  logic unused_domain;
  assign unused_domain = domain;

  logic [p_msg_nbits-1:0]  msg_mem_q   [p_num_entries];
  logic [p_msg_nbits-1:0]  msg_mem_d   [p_num_entries];
  logic [1:0]              route_mem_q [p_num_entries];
  logic [1:0]              route_mem_d [p_num_entries];
  logic [c_ptr_nbits-1:0]  head_q, head_d;
  logic [c_ptr_nbits-1:0]  tail_q, tail_d;
  logic [c_cnt_nbits-1:0]  count_q, count_d;

  logic [c_dest_nbits-1:0] dest, fwd, bwd;
  logic [1:0]              in_route;
  logic [1:0]              head_route;
  logic                    empty, enq, deq;

  // Greedy route for the incoming message, modulo ring size; ties go to prev.
  always_comb begin
    dest = in_msg[p_msg_nbits-1 -: c_dest_nbits];
    fwd  = dest - c_id;
    bwd  = c_id - dest;
    if (dest == c_id)   in_route = ROUTE_TERM;
    else if (fwd < bwd) in_route = ROUTE_NEXT;
    else                in_route = ROUTE_PREV;
  end

  // Head presentation: one-hot request from the stored route, zeroed when empty.
  always_comb begin
    empty      = (count_q == '0);
    head_route = route_mem_q[head_q];
    out_val    = 3'b000;
    route      = ROUTE_PREV;
    out_msg    = '0;
    if (!empty) begin
      route   = head_route;
      out_msg = msg_mem_q[head_q];
      case (head_route)
        ROUTE_PREV: out_val = 3'b001;
        ROUTE_NEXT: out_val = 3'b010;
        ROUTE_TERM: out_val = 3'b100;
        default:    out_val = 3'b000;
      endcase
    end
    // Grants on outputs that are not being requested are ignored.
    deq    = |(out_val & out_rdy);
    in_rdy = (count_q != c_full);
    enq    = in_val && in_rdy;
  end

  // Next-state for pointers, occupancy and the storage array.
  always_comb begin
    head_d      = deq ? head_q + 1'b1 : head_q;
    tail_d      = enq ? tail_q + 1'b1 : tail_q;
    count_d     = count_q;
    msg_mem_d   = msg_mem_q;
    route_mem_d = route_mem_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (enq) begin
      msg_mem_d[tail_q]   = in_msg;
      route_mem_d[tail_q] = in_route;
    end
  end

  // Control state; reset drops every queued message at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array is not reset; out_msg is masked while empty instead.
  always_ff @(posedge clk) begin
    msg_mem_q   <= msg_mem_d;
    route_mem_q <= route_mem_d;
  end

endmodule

// File: tb/tb_ring_router_input_unit.sv
// Directed bench for ring_router_input_unit: a vector table for the route
// decode, backpressure, wrong-port grant and streaming cases on router 2 of 8,
// plus hand-written sequences for async reset and the tie case on router 0 of 4.
module tb_ring_router_input_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val, in_rdy;
  logic [43:0] in_msg, out_msg;
  logic [2:0]  out_val, out_rdy;
  logic [1:0]  route;

  logic        in_val2, in_rdy2;
  logic [43:0] in_msg2, out_msg2;
  logic [2:0]  out_val2, out_rdy2;
  logic [1:0]  route2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_router_input_unit #(
    .p_router_id(2), .p_num_routers(8), .p_msg_nbits(44), .p_num_entries(2)
  ) dut (
    .clk(clk), .reset(reset), .domain(1'b0),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy), .route(route)
  );

  ring_router_input_unit #(
    .p_router_id(0), .p_num_routers(4), .p_msg_nbits(44), .p_num_entries(2)
  ) dut_tie (
    .clk(clk), .reset(reset), .domain(1'b1),
    .in_val(in_val2), .in_rdy(in_rdy2), .in_msg(in_msg2),
    .out_msg(out_msg2), .out_val(out_val2), .out_rdy(out_rdy2), .route(route2)
  );

  typedef struct {
    string       name;
    logic        in_val;
    logic [43:0] in_msg;
    logic [2:0]  out_rdy;
    logic        exp_in_rdy;
    logic [2:0]  exp_val;
    logic [1:0]  exp_route;
    logic [43:0] exp_msg;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [43:0] mk1(input int d, input int tag);
    return {3'(d), 41'(tag)};
  endfunction

  function automatic logic [43:0] mk2(input int d, input int tag);
    return {2'(d), 42'(tag)};
  endfunction

  function automatic logic [1:0] code_of(input logic [2:0] v);
    return (v == 3'b100) ? 2'b10 : (v == 3'b010) ? 2'b01 : 2'b00;
  endfunction

  function automatic void add(input string nm, input bit iv, input int idest,
                              input int itag, input logic [2:0] rdy, input bit erdy,
                              input logic [2:0] ev, input int edest, input int etag);
    vec_t v;
    v.name       = nm;
    v.in_val     = iv;
    v.in_msg     = iv ? mk1(idest, itag) : 44'd0;
    v.out_rdy    = rdy;
    v.exp_in_rdy = erdy;
    v.exp_val    = ev;
    v.exp_route  = code_of(ev);
    v.exp_msg    = (ev == 3'b000) ? 44'd0 : mk1(edest, etag);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_dut1(input string nm, input logic erdy, input logic [2:0] ev,
                          input logic [43:0] emsg);
    chk({nm, ".in_rdy"},  64'(in_rdy),  64'(erdy));
    chk({nm, ".out_val"}, 64'(out_val), 64'(ev));
    chk({nm, ".route"},   64'(route),   64'(code_of(ev)));
    chk({nm, ".out_msg"}, 64'(out_msg), 64'(emsg));
  endtask

  // Hand-computed routes for dest 0..7 on router 2 of 8 (6 is a tie -> prev).
  logic [2:0] str_val [8] = '{3'b001, 3'b001, 3'b100, 3'b010,
                              3'b010, 3'b010, 3'b001, 3'b001};
  // Router 0 of 4: dest 2 tie -> prev, 1 -> next, 3 -> prev, 0 -> term.
  int         tie_dest [4] = '{2, 1, 3, 0};
  logic [2:0] tie_val  [4] = '{3'b001, 3'b010, 3'b001, 3'b100};

  initial begin
    reset = 1'b0; in_val = 1'b0; in_msg = '0; out_rdy = 3'b000;
    in_val2 = 1'b0; in_msg2 = '0; out_rdy2 = 3'b000;

    // Route decode, router 2: dest 2,3,5,6,7 with all grants.
    add("dec0", 1, 2, 1, 3'b111, 1, 3'b000, 0, 0);
    add("dec1", 1, 3, 2, 3'b111, 1, 3'b100, 2, 1);
    add("dec2", 1, 5, 3, 3'b111, 1, 3'b010, 3, 2);
    add("dec3", 1, 6, 4, 3'b111, 1, 3'b010, 5, 3);
    add("dec4", 1, 7, 5, 3'b111, 1, 3'b001, 6, 4);
    add("dec5", 0, 0, 0, 3'b111, 1, 3'b001, 7, 5);
    add("dec6", 0, 0, 0, 3'b111, 1, 3'b000, 0, 0);
    // Fill/backpressure: A(d3) B(d6) accepted, C D refused, then drain.
    add("bp0", 1, 3, 10, 3'b000, 1, 3'b000, 0, 0);
    add("bp1", 1, 6, 11, 3'b000, 1, 3'b010, 3, 10);
    add("bp2", 1, 1, 12, 3'b000, 0, 3'b010, 3, 10);
    add("bp3", 1, 5, 13, 3'b000, 0, 3'b010, 3, 10);
    add("bp4", 0, 0, 0,  3'b111, 0, 3'b010, 3, 10);
    add("bp5", 0, 0, 0,  3'b111, 1, 3'b001, 6, 11);
    add("bp6", 0, 0, 0,  3'b111, 1, 3'b000, 0, 0);
    // Wrong-port grant: head wants next, only prev/term granted.
    add("wp0", 1, 4, 20, 3'b000, 1, 3'b000, 0, 0);
    add("wp1", 0, 0, 0,  3'b101, 1, 3'b010, 4, 20);
    add("wp2", 0, 0, 0,  3'b101, 1, 3'b010, 4, 20);
    add("wp3", 0, 0, 0,  3'b101, 1, 3'b010, 4, 20);
    add("wp4", 0, 0, 0,  3'b010, 1, 3'b010, 4, 20);
    add("wp5", 0, 0, 0,  3'b000, 1, 3'b000, 0, 0);
    // Full-throughput stream of 8, simultaneous enq/deq at count 1, pointer wrap.
    add("str0", 1, 0, 30, 3'b111, 1, 3'b000, 0, 0);
    for (int i = 1; i < 8; i++)
      add($sformatf("str%0d", i), 1, i, 30 + i, 3'b111, 1, str_val[i-1], i - 1, 29 + i);
    add("str8", 0, 0, 0, 3'b111, 1, str_val[7], 7, 37);
    add("str9", 0, 0, 0, 3'b111, 1, 3'b000, 0, 0);

    // Reset state, while reset is held.
    #2;
    chk_dut1("rst", 1'b1, 3'b000, 44'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      in_val  = vecs[i].in_val;
      in_msg  = vecs[i].in_msg;
      out_rdy = vecs[i].out_rdy;
      #2;
      chk({vecs[i].name, ".in_rdy"},  64'(in_rdy),  64'(vecs[i].exp_in_rdy));
      chk({vecs[i].name, ".out_val"}, 64'(out_val), 64'(vecs[i].exp_val));
      chk({vecs[i].name, ".route"},   64'(route),   64'(vecs[i].exp_route));
      chk({vecs[i].name, ".out_msg"}, 64'(out_msg), 64'(vecs[i].exp_msg));
      @(posedge clk); #1;
    end

    // Async reset with two messages queued.
    in_val = 1'b1; in_msg = mk1(5, 40); out_rdy = 3'b000;
    @(posedge clk); #1;
    in_msg = mk1(7, 41);
    @(posedge clk); #1;
    in_val = 1'b0; in_msg = '0;
    #1;
    chk_dut1("full", 1'b0, 3'b010, mk1(5, 40));
    reset = 1'b0;
    #1;
    chk_dut1("arst", 1'b1, 3'b000, 44'd0);
    @(posedge clk); #4;
    reset = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b1; in_msg = mk1(0, 50);
    #2;
    chk_dut1("post0", 1'b1, 3'b000, 44'd0);
    @(posedge clk); #1;
    in_val = 1'b0; in_msg = '0;
    #2;
    chk_dut1("post1", 1'b1, 3'b001, mk1(0, 50));
    out_rdy = 3'b111;
    @(posedge clk); #1;
    #2;
    chk_dut1("post2", 1'b1, 3'b000, 44'd0);
    out_rdy = 3'b000;

    // Tie case on router 0 of 4.
    out_rdy2 = 3'b111;
    for (int i = 0; i <= 4; i++) begin
      in_val2 = (i < 4);
      in_msg2 = (i < 4) ? mk2(tie_dest[i], 60 + i) : 44'd0;
      #2;
      if (i == 0) begin
        chk("tie0.out_val", 64'(out_val2), 64'(3'b000));
      end else begin
        chk($sformatf("tie%0d.out_val", i), 64'(out_val2), 64'(tie_val[i-1]));
        chk($sformatf("tie%0d.route", i),   64'(route2),   64'(code_of(tie_val[i-1])));
        chk($sformatf("tie%0d.out_msg", i), 64'(out_msg2), 64'(mk2(tie_dest[i-1], 59 + i)));
      end
      chk($sformatf("tie%0d.in_rdy", i), 64'(in_rdy2), 64'(1'b1));
      @(posedge clk); #1;
    end
    #2;
    chk("tie_end.out_val", 64'(out_val2), 64'(3'b000));
    chk("tie_end.out_msg", 64'(out_msg2), 64'(44'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
